// File: rtl/io_port_if.sv
// Processor-side bus between the pico MIPS decoder/register file and io_port.
// Handshake: stall=1 means the current STIN has no data yet; the core holds PC and suppresses the write.
interface io_port_if #(
    parameter int DATA_W = 8
);
    logic              read_in;
    logic              write_out;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              stall;

    modport master (
        output read_in, write_out, wr_data,
        input  rd_data, stall
    );

    modport slave (
        input  read_in, write_out, wr_data,
        output rd_data, stall
    );
endinterface

// File: rtl/io_port.sv
// STIN/LOUT responder: debounced push-button latches switches into a one-entry buffer,
// STIN stalls until the buffer is full, LOUT drives an LED register.
module io_port #(
    parameter int DATA_W          = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    io_port_if.slave          bus,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              sw_strobe,
    output logic [DATA_W-1:0] led_out,
    output logic              led_valid,
    output logic              overrun,
    output logic [1:0]        dbg_state,
    output logic              dbg_in_full,
    output logic              dbg_press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    logic             sync1, s;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press;
    logic [DATA_W-1:0] in_buf;
    logic             in_full;
    logic             consume;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= sw_strobe;
            s     <= sync1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press   = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    press   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                // A bounce back high returns to PRESSED without a new event.
                if (s) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign consume = bus.read_in & in_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_buf  <= '0;
            in_full <= 1'b0;
            overrun <= 1'b0;
        end else if (press) begin
            // A read consuming the old value frees the slot for this press.
            if (!in_full || consume) begin
                in_buf  <= sw_data;
                in_full <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (consume) begin
            in_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_out   <= '0;
            led_valid <= 1'b0;
        end else if (bus.write_out) begin
            led_out   <= bus.wr_data;
            led_valid <= 1'b1;
        end
    end

    assign bus.rd_data = in_buf;
    assign bus.stall   = bus.read_in & ~in_full & ~reset;

    assign dbg_state   = state_q;
    assign dbg_in_full = in_full;
    assign dbg_press   = press & ~reset;
endmodule

// File: doc/io_port.md
# io_port

Processor-side I/O responder for the pico MIPS core: it services the decoder's `read_in` (STIN) and `write_out` (LOUT) strobes. It debounces a board push-button, latches the 8-bit switch value on each debounced press, and delivers that value to the register-file write path. It stalls the core while a STIN waits for data. It latches LOUT data onto an LED register.

## Interface
- `DATA_W`, 8, width of switch, LED and register-file data.
- `DEBOUNCE_CYCLES`, 4, consecutive stable samples required to accept a press or release. Must be ≥2; board builds override with a large value.

- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `read_in`  in  1  from decoder; current instruction is STIN.
- `write_out`  in  1  from decoder; current instruction is LOUT.
- `wr_data`  in  DATA_W  register-file read port feeding LOUT.
- `rd_data`  out  DATA_W  value returned to the register-file write mux for STIN.
- `stall`  out  1  freezes PC and suppresses register write for the current cycle.
- `sw_data`  in  DATA_W  board switches; quasi-static, no synchroniser.
- `sw_strobe`  in  1  raw asynchronous push-button.
- `led_out`  out  DATA_W  LED register.
- `led_valid`  out  1  set by the first LOUT after reset; sticky.
- `overrun`  out  1  sticky; a press was dropped because the buffer was full.

## Operation
- Synchroniser: two flops on `sw_strobe`; the second flop output is `s`.
- Debounce FSM, states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, with counter `cnt` of width $clog2(DEBOUNCE_CYCLES+1):
  - IDLE: `s`=1 moves to PRESS_WAIT with `cnt`=1.
  - PRESS_WAIT: `s`=0 moves to IDLE with `cnt`=0. `s`=1 with `cnt`==DEBOUNCE_CYCLES-1 moves to PRESSED and raises the one-cycle press event. Otherwise `cnt`++.
  - PRESSED: `s`=0 moves to RELEASE_WAIT with `cnt`=1.
  - RELEASE_WAIT: `s`=1 moves to PRESSED. `s`=0 with `cnt`==DEBOUNCE_CYCLES-1 moves to IDLE with `cnt`=0. Otherwise `cnt`++.
- Input buffer `in_buf`/`in_full`:
  - On a press event, `in_buf`<=`sw_data` and `in_full`<=1.
  - If `in_full`=1 and no consuming read happens in the same cycle, the press is dropped and `overrun`<=1.
- STIN:
  - `rd_data`=`in_buf` combinationally at all times.
  - `stall` = `read_in` & ~`in_full` & ~`reset`.
  - `read_in` with `in_full`=1 consumes the data: `in_full`<=0 at the edge.
- Simultaneous consuming read and press event: the read returns the old `in_buf`. The new value is captured and `in_full` stays 1. No overrun.
- LOUT: at the edge with `write_out`=1, `led_out`<=`wr_data` and `led_valid`<=1. LOUT never stalls.
- `read_in` and `write_out` high together (not produced by the decoder): both actions are performed independently.
- Reset (any cycle, including mid-debounce or mid-stall):
  - Sync flops 0, FSM IDLE, `cnt` 0, no press event.
  - `in_buf`, `in_full`, `overrun`, `led_out`, `led_valid` all 0.
  - `stall` is forced to 0 while `reset` is high.

## Timing
- `stall` and `rd_data` are combinational from registers plus `read_in`. There is no extra read latency when `in_full`=1.
- Press latency: with `sw_strobe` stable high from before edge E0, `s` is first sampled high at E2. `in_full` is 1 after edge E(DEBOUNCE_CYCLES+1), which is E5 with the default.
- A stalled STIN completes in the cycle after `in_full` rises: `stall` drops and the write occurs at the next edge.
- Glitches shorter than DEBOUNCE_CYCLES samples produce no event. A release glitch of the same length does not re-arm the FSM.
- Only one press event per debounced press/release cycle. Holding the button never repeats the event.
- LOUT latency: `led_out` updates at the edge of the LOUT cycle.

## Test plan
- After reset, check all outputs are 0. Then hold `sw_strobe` high with `sw_data`=8'hA5 and DEBOUNCE_CYCLES=4 -> `in_full` is 1 after E5; `rd_data`=8'hA5; exactly one press event.
- Assert `read_in` with the buffer empty, then perform a press with `sw_data`=8'h3C -> `stall`=1 until the cycle after `in_full` rises. Then `stall`=0, `rd_data`=8'h3C, and `in_full` is 0 after the next edge.
- Pulse `sw_strobe` high for 3 samples, then low -> FSM returns to IDLE, `in_full` stays 0. Then bounce high/low/high during release -> no second event.
- Make two debounced presses (8'h11, then 8'h22) without any read -> `in_buf`=8'h11, `overrun`=1. Then make a press event and a consuming read in the same cycle -> read returns the old value, the new value is buffered, `overrun` is unchanged.
- Drive `write_out` with `wr_data`=8'hF0, then 8'h0F -> `led_out` follows at each edge; `led_valid`=1 and stays 1.
- Assert `reset` mid-PRESS_WAIT and during a stalled STIN -> `stall`=0 in the reset cycle, FSM is in IDLE, and no capture occurs after reset is released unless a full new debounce completes.
